// File: rtl/nn_core_pkg.sv
// Shared NN core definitions: default widths, the decoded-instruction bundle and helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: NUM_ADDR_BITS/REG_WIDTH/OPC_BITS/IMM_WIDTH defaults, fetchBundle_t, signExtImm().
package nn_core_pkg;

  localparam int NUM_ADDR_BITS = 6;
  localparam int REG_WIDTH     = 32;
  localparam int OPC_BITS      = 6;
  localparam int IMM_WIDTH     = 16;

  // Decoded instruction once its operands are resolved; this is what execute consumes.
  typedef struct packed {
    logic [OPC_BITS-1:0]      opcode;
    logic [NUM_ADDR_BITS-1:0] rd;
    logic                     writesRd;
    logic [REG_WIDTH-1:0]     opA;
    logic [REG_WIDTH-1:0]     opB;
    logic [REG_WIDTH-1:0]     imm;
  } fetchBundle_t;

  function automatic logic [REG_WIDTH-1:0] signExtImm(input logic [IMM_WIDTH-1:0] imm);
    return {{(REG_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_scoreboard.sv
// Per-register busy scoreboard for the operand-fetch stage.
// Latency: set/clear take effect at the next edge; lookups are combinational.
// Backpressure: none; the owner decides when set/clear fire.
// Ports: clk, reset; setEn/setAddr (new producer); clrEn/clrAddr (writeback);
//        rsAddr/rtAddr/rdAddr lookups -> busyRs/busyRt/busyRd.
module fetch_scoreboard
  import nn_core_pkg::*;
#(
  parameter int ADDR_BITS = NUM_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 setEn,
  input  logic [ADDR_BITS-1:0] setAddr,
  input  logic                 clrEn,
  input  logic [ADDR_BITS-1:0] clrAddr,
  input  logic [ADDR_BITS-1:0] rsAddr,
  input  logic [ADDR_BITS-1:0] rtAddr,
  input  logic [ADDR_BITS-1:0] rdAddr,
  output logic                 busyRs,
  output logic                 busyRt,
  output logic                 busyRd
);

  localparam int NUM_REGS = 2 ** ADDR_BITS;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;

  // Set is applied after clear so a new producer keeps ownership when its
  // predecessor retires on the same edge. Register 0 is hard-wired idle.
  always_comb begin
    busyNext = busy;
    if (clrEn) busyNext[clrAddr] = 1'b0;
    if (setEn) busyNext[setAddr] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busyNext;
  end

  assign busyRs = busy[rsAddr];
  assign busyRt = busy[rtAddr];
  assign busyRd = busy[rdAddr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads the regfile, forwards writeback data, tracks busy regs, stalls on RAW/WAW.
// Latency: 1 cycle from accept edge to out_valid.
// Backpressure: in_ready drops on hazards or when a held bundle is not taken by execute.
// Ports: clk, reset; decoder side in_*; regfile rf_rdAddrA/B, rf_rdDataA/B;
//        writeback wb_valid/wb_addr/wb_data; execute side out_*.
module operand_fetch #(
  parameter int NUM_ADDR_BITS = nn_core_pkg::NUM_ADDR_BITS,
  parameter int REG_WIDTH     = nn_core_pkg::REG_WIDTH,
  parameter int OPC_BITS      = nn_core_pkg::OPC_BITS,
  parameter int IMM_WIDTH     = nn_core_pkg::IMM_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPC_BITS-1:0]      in_opcode,
  input  logic [NUM_ADDR_BITS-1:0] in_rd,
  input  logic [NUM_ADDR_BITS-1:0] in_rs,
  input  logic [NUM_ADDR_BITS-1:0] in_rt,
  input  logic [IMM_WIDTH-1:0]     in_imm,
  input  logic                     in_uses_rs,
  input  logic                     in_uses_rt,
  input  logic                     in_writes_rd,
  output logic [NUM_ADDR_BITS-1:0] rf_rdAddrA,
  output logic [NUM_ADDR_BITS-1:0] rf_rdAddrB,
  input  logic [REG_WIDTH-1:0]     rf_rdDataA,
  input  logic [REG_WIDTH-1:0]     rf_rdDataB,
  input  logic                     wb_valid,
  input  logic [NUM_ADDR_BITS-1:0] wb_addr,
  input  logic [REG_WIDTH-1:0]     wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPC_BITS-1:0]      out_opcode,
  output logic [NUM_ADDR_BITS-1:0] out_rd,
  output logic                     out_writes_rd,
  output logic [REG_WIDTH-1:0]     out_opA,
  output logic [REG_WIDTH-1:0]     out_opB,
  output logic [REG_WIDTH-1:0]     out_imm
);

  import nn_core_pkg::*;

  logic         wbLive;
  logic         wbHitRs;
  logic         wbHitRt;
  logic         wbHitRd;
  logic         busyRs;
  logic         busyRt;
  logic         busyRd;
  logic         rawHazard;
  logic         wawHazard;
  logic         accept;
  logic [REG_WIDTH-1:0] opA;
  logic [REG_WIDTH-1:0] opB;
  fetchBundle_t nextBundle;
  fetchBundle_t outReg;
  logic         outValid;

  assign rf_rdAddrA = in_rs;
  assign rf_rdAddrB = in_rt;

  // r0 writebacks carry no meaning: they neither forward nor touch the scoreboard.
  assign wbLive  = wb_valid && (wb_addr != '0);
  assign wbHitRs = wbLive && (wb_addr == in_rs);
  assign wbHitRt = wbLive && (wb_addr == in_rt);
  assign wbHitRd = wbLive && (wb_addr == in_rd);

  // The regfile write lands on the same edge we capture, so a matching
  // writeback must bypass the (still stale) regfile read.
  assign opA = (!in_uses_rs || in_rs == '0) ? '0 : (wbHitRs ? wb_data : rf_rdDataA);
  assign opB = (!in_uses_rt || in_rt == '0) ? '0 : (wbHitRt ? wb_data : rf_rdDataB);

  fetch_scoreboard #(
    .ADDR_BITS (NUM_ADDR_BITS)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .setEn   (accept && in_writes_rd && (in_rd != '0)),
    .setAddr (in_rd),
    .clrEn   (wbLive),
    .clrAddr (wb_addr),
    .rsAddr  (in_rs),
    .rtAddr  (in_rt),
    .rdAddr  (in_rd),
    .busyRs  (busyRs),
    .busyRt  (busyRt),
    .busyRd  (busyRd)
  );

  // A busy register being written back this cycle is effectively free.
  assign rawHazard = (in_uses_rs && busyRs && !wbHitRs) ||
                     (in_uses_rt && busyRt && !wbHitRt);
  assign wawHazard = in_writes_rd && busyRd && !wbHitRd;

  assign in_ready = !rawHazard && !wawHazard && (!outValid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    nextBundle          = '0;
    nextBundle.opcode   = in_opcode;
    nextBundle.rd       = in_rd;
    nextBundle.writesRd = in_writes_rd;
    nextBundle.opA      = opA;
    nextBundle.opB      = opB;
    nextBundle.imm      = signExtImm(in_imm);
  end

  // Fields only change on accept, so they stay stable while execute stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid <= 1'b0;
      outReg   <= '0;
    end else if (accept) begin
      outValid <= 1'b1;
      outReg   <= nextBundle;
    end else if (out_ready) begin
      outValid <= 1'b0;
    end
  end

  assign out_valid     = outValid;
  assign out_opcode    = outReg.opcode;
  assign out_rd        = outReg.rd;
  assign out_writes_rd = outReg.writesRd;
  assign out_opA       = outReg.opA;
  assign out_opB       = outReg.opB;
  assign out_imm       = outReg.imm;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed vectors, expected bundles queued at issue,
// a negedge monitor pops and compares every bundle execute takes.
// Also models the regfile (combinational read, write at posedge on wb_valid).
module tb_operand_fetch;
  import nn_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_rd;
  logic [5:0]  in_rs;
  logic [5:0]  in_rt;
  logic [15:0] in_imm;
  logic        in_uses_rs;
  logic        in_uses_rt;
  logic        in_writes_rd;
  logic [5:0]  rf_rdAddrA;
  logic [5:0]  rf_rdAddrB;
  logic [31:0] rf_rdDataA;
  logic [31:0] rf_rdDataB;
  logic        wb_valid;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [5:0]  out_rd;
  logic        out_writes_rd;
  logic [31:0] out_opA;
  logic [31:0] out_opB;
  logic [31:0] out_imm;

  int checks = 0;
  int passes = 0;
  fetchBundle_t expQ[$];

  logic [31:0] rf [64];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_writes_rd(in_writes_rd),
    .rf_rdAddrA(rf_rdAddrA), .rf_rdAddrB(rf_rdAddrB),
    .rf_rdDataA(rf_rdDataA), .rf_rdDataB(rf_rdDataB),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_writes_rd(out_writes_rd),
    .out_opA(out_opA), .out_opB(out_opB), .out_imm(out_imm)
  );

  assign rf_rdDataA = rf[rf_rdAddrA];
  assign rf_rdDataB = rf[rf_rdAddrB];

  always @(posedge clk) begin
    if (wb_valid && wb_addr != 6'd0) rf[wb_addr] <= wb_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic fetchBundle_t mk(input logic [5:0] opc, input logic [5:0] rd,
                                      input logic wr, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] imm);
    fetchBundle_t t;
    t.opcode = opc; t.rd = rd; t.writesRd = wr; t.opA = a; t.opB = b; t.imm = imm;
    return t;
  endfunction

  // Monitor: every bundle execute takes must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        fetchBundle_t e;
        e = expQ.pop_front();
        check("out_opcode",    32'(out_opcode),    32'(e.opcode));
        check("out_rd",        32'(out_rd),        32'(e.rd));
        check("out_writes_rd", 32'(out_writes_rd), 32'(e.writesRd));
        check("out_opA",       out_opA,            e.opA);
        check("out_opB",       out_opB,            e.opB);
        check("out_imm",       out_imm,            e.imm);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] opc, input logic [5:0] rd, input logic [5:0] rs,
                       input logic [5:0] rt, input logic [15:0] imm,
                       input logic urs, input logic urt, input logic wr);
    in_valid = 1'b1; in_opcode = opc; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    in_uses_rs = urs; in_uses_rt = urt; in_writes_rd = wr;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_uses_rs = 1'b0; in_uses_rt = 1'b0; in_writes_rd = 1'b0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_opcode = '0; in_imm = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = 32'd0;
    rf[0] = 32'hDEADBEEF;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    reset = 1'b1; out_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    idle();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_opA", out_opA, 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Back-to-back independent instructions, one per cycle.
    step(); drive(6'd1, 6'd10, 6'd1, 6'd2, 16'h0004, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_ready", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd1, 6'd10, 1'b0, 32'd5, 32'd7, 32'h4));
    // rs = r0 gives 0 despite regfile[0]; a writeback to r0 must not forward.
    step(); drive(6'd2, 6'd11, 6'd0, 6'd1, 16'h8001, 1'b1, 1'b1, 1'b0);
    wb_valid = 1'b1; wb_addr = 6'd0; wb_data = 32'h999;
    @(negedge clk);
    check("t1_latency", 32'(out_valid), 32'd1);
    check("t2_ready", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd2, 6'd11, 1'b0, 32'd0, 32'd5, 32'hFFFF8001));
    // Unused rt yields 0; positive immediate stays positive.
    step(); drive(6'd3, 6'd12, 6'd2, 6'd1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    wb_valid = 1'b0;
    @(negedge clk);
    check("t3_ready", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd3, 6'd12, 1'b0, 32'd7, 32'd0, 32'h00007FFF));
    step(); idle();
    @(negedge clk);
    @(negedge clk);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // RAW: I1 writes r3, I2 reads r3 and waits for the writeback.
    step(); drive(6'd4, 6'd3, 6'd1, 6'd2, 16'h0000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("i1_ready", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd4, 6'd3, 1'b1, 32'd5, 32'd7, 32'd0));
    step(); drive(6'd5, 6'd13, 6'd3, 6'd1, 16'h0010, 1'b1, 1'b1, 1'b0);
    @(negedge clk); check("raw_stall0", 32'(in_ready), 32'd0);
    step();
    @(negedge clk); check("raw_stall1", 32'(in_ready), 32'd0);
    step();
    @(negedge clk); check("raw_stall2", 32'(in_ready), 32'd0);
    step(); wb_valid = 1'b1; wb_addr = 6'd3; wb_data = 32'h1234;
    @(negedge clk);
    check("raw_fwd_ready", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd5, 6'd13, 1'b0, 32'h1234, 32'd5, 32'h10));
    step(); wb_valid = 1'b0;
    drive(6'd6, 6'd14, 6'd3, 6'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("r3_cleared", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd6, 6'd14, 1'b0, 32'h1234, 32'd0, 32'd0));

    // Execute backpressure: output holds for 3 cycles, then next accept on release.
    step(); drive(6'd7, 6'd15, 6'd1, 6'd2, 16'h0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("hold_a_ready", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd7, 6'd15, 1'b0, 32'd5, 32'd7, 32'd0));
    step(); out_ready = 1'b0;
    drive(6'd8, 6'd16, 6'd2, 6'd2, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_opA", out_opA, 32'd5);
      check("hold_opcode", 32'(out_opcode), 32'd7);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd8, 6'd16, 1'b0, 32'd7, 32'd7, 32'hFFFFFFFF));

    // Same-edge set/clear on r4: the new producer keeps r4 busy.
    step(); drive(6'd9, 6'd4, 6'd1, 6'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
    wb_valid = 1'b1; wb_addr = 6'd4; wb_data = 32'h44;
    @(negedge clk);
    check("setclr_ready", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd9, 6'd4, 1'b1, 32'd5, 32'd0, 32'd0));
    step(); wb_valid = 1'b0;
    drive(6'd10, 6'd17, 6'd4, 6'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("r4_busy_raw", 32'(in_ready), 32'd0);
    step(); drive(6'd11, 6'd4, 6'd0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("r4_busy_waw", 32'(in_ready), 32'd0);

    // Reset mid-stall with a held bundle in the output register.
    step(); out_ready = 1'b0;
    drive(6'd12, 6'd18, 6'd1, 6'd1, 16'h0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("pre_rst_ready", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd12, 6'd18, 1'b0, 32'd5, 32'd5, 32'd0));
    step(); drive(6'd10, 6'd17, 6'd4, 6'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_stall", 32'(in_ready), 32'd0);
    step(); reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_opA", out_opA, 32'd0);
    check("mid_rst_opcode", 32'(out_opcode), 32'd0);
    expQ.delete();
    step(); reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_busy_clear", 32'(in_ready), 32'd1);
    expQ.push_back(mk(6'd10, 6'd17, 1'b0, 32'h44, 32'd0, 32'd0));
    step(); idle();
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
